// File: rtl/byte_encode_ctrl_pkg.sv
// Shared Kyber package: defaults, FSM state encoding and the bit-insert
// helper used by the byte packer.
package byte_encode_ctrl_pkg;

    localparam int N_COEFF_DEF = 256;
    localparam int MAX_D_DEF   = 12;
    localparam int ACC_W       = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Keep the low d bits of data and OR them into acc starting at bit pos.
    function automatic logic [ACC_W-1:0] insert_bits(
        input logic [ACC_W-1:0] acc,
        input logic [ACC_W-1:0] data,
        input logic [3:0]       d,
        input logic [4:0]       pos
    );
        logic [ACC_W-1:0] mask;
        mask = (20'd1 << d) - 20'd1;
        return acc | ((data & mask) << pos);
    endfunction

endpackage

// File: rtl/byte_encode_ctrl.sv
// Packs N_COEFF coefficients of d bits each (LSB first) into a byte stream.
// Handshake-driven on both sides; illegal d completes immediately with err.
module byte_encode_ctrl
    import byte_encode_ctrl_pkg::*;
#(
    parameter int N_COEFF = N_COEFF_DEF,
    parameter int MAX_D   = MAX_D_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       d,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             coeff_valid,
    output logic             coeff_ready,
    input  logic [MAX_D-1:0] coeff_data,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic [7:0]       byte_data
);

    localparam int CCNT_W = $clog2(N_COEFF + 1);
    localparam int OCNT_W = $clog2((N_COEFF * MAX_D) / 8 + 1);

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          d_r;
    logic [ACC_W-1:0]    acc_r;
    logic [4:0]          bcnt_r;
    logic [CCNT_W-1:0]   ccnt_r;
    logic [OCNT_W-1:0]   ocnt_r;
    logic                busy_r;
    logic                done_r;
    logic                err_r;

    logic                d_legal_s;
    logic                accept_s;
    logic                coeff_hs_s;
    logic                byte_hs_s;
    logic                last_byte_s;
    logic [OCNT_W-1:0]   total_bytes_s;

    assign d_legal_s     = (d != 4'd0) && (int'(d) <= MAX_D);
    assign accept_s      = (state_r == IDLE) && start;
    assign total_bytes_s = OCNT_W'((N_COEFF * int'(d_r)) / 8);

    // Ready/valid are decoded purely from registered state so they never
    // combinationally depend on the partner's handshake signal.
    assign coeff_ready = (state_r == RUN) && (ccnt_r < CCNT_W'(N_COEFF)) && (bcnt_r < 5'd8);
    assign byte_valid  = (state_r == RUN) && (bcnt_r >= 5'd8);
    assign byte_data   = acc_r[7:0];

    assign coeff_hs_s  = coeff_valid && coeff_ready;
    assign byte_hs_s   = byte_valid && byte_ready;
    assign last_byte_s = byte_hs_s && (ocnt_r == total_bytes_s - OCNT_W'(1));

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

    // Next-state decode for the operation sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (d_legal_s) begin
                        state_s = RUN;
                    end else begin
                        state_s = FIN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_byte_s) begin
                    state_s = FIN;
                end else begin
                    state_s = RUN;
                end
            end
            FIN:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register plus registered status outputs derived from next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= (state_s == FIN);
            // FIN is only reachable straight from IDLE via an illegal d.
            err_r   <= (state_s == FIN) && (state_r == IDLE);
        end
    end

    // Accumulator, fill count and progress counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_r    <= 4'd0;
            acc_r  <= '0;
            bcnt_r <= 5'd0;
            ccnt_r <= '0;
            ocnt_r <= '0;
        end else if (accept_s) begin
            d_r    <= d;
            acc_r  <= '0;
            bcnt_r <= 5'd0;
            ccnt_r <= '0;
            ocnt_r <= '0;
        end else if (coeff_hs_s) begin
            acc_r  <= insert_bits(acc_r, ACC_W'(coeff_data), d_r, bcnt_r);
            bcnt_r <= bcnt_r + {1'b0, d_r};
            ccnt_r <= ccnt_r + CCNT_W'(1);
        end else if (byte_hs_s) begin
            acc_r  <= acc_r >> 8;
            bcnt_r <= bcnt_r - 5'd8;
            ocnt_r <= ocnt_r + OCNT_W'(1);
        end else begin
            acc_r  <= acc_r;
            bcnt_r <= bcnt_r;
        end
    end

endmodule

// File: tb/tb_byte_encode_ctrl.sv
// Directed bench for byte_encode_ctrl: fixed patterns with hand-known bytes,
// a stalled d=10 run against a bit-stream model, illegal d and mid-run reset.
module tb_byte_encode_ctrl;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  d;
    logic        busy, done, err;
    logic        coeff_valid, coeff_ready;
    logic [11:0] coeff_data;
    logic        byte_valid, byte_ready;
    logic [7:0]  byte_data;

    always #5 clk = ~clk;

    byte_encode_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .d(d),
        .busy(busy), .done(done), .err(err),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready), .coeff_data(coeff_data),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data)
    );

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [11:0] cvals [N];
    logic [7:0]  got_q [$];
    int          n_coeff_hs;
    bit          done_seen, err_seen, timeout, stable_bad, busy_bad, done_wide;

    // Drives one operation; records handshakes as seen by the bench itself.
    task automatic run_op(input logic [3:0] dval, input bit stall, input int abort_at);
        logic [7:0] held;
        bit holding;
        got_q.delete();
        n_coeff_hs = 0; done_seen = 0; err_seen = 0; timeout = 1;
        stable_bad = 0; busy_bad = 0; done_wide = 0; holding = 0; held = 8'h00;
        coeff_valid = 1'b0; byte_ready = 1'b0; start = 1'b1; d = dval;
        @(posedge clk); #1;
        start = 1'b0; d = 4'd3;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (abort_at > 0 && got_q.size() >= abort_at) begin
                timeout = 0;
                break;
            end
            if (done) begin
                done_seen = 1; err_seen = err; timeout = 0;
                coeff_valid = 1'b0; byte_ready = 1'b0;
                @(posedge clk); #1;
                if (done || busy) done_wide = 1;
                break;
            end
            if (!busy) busy_bad = 1;
            if (holding && (!byte_valid || byte_data !== held)) stable_bad = 1;
            start       = stall && (cyc == 100);
            d           = start ? 4'd0 : 4'd3;
            coeff_valid = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            coeff_data  = (n_coeff_hs < N) ? cvals[n_coeff_hs] : 12'hFFF;
            byte_ready  = stall ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (coeff_valid && coeff_ready) n_coeff_hs++;
            holding = byte_valid && !byte_ready;
            held    = byte_data;
            if (byte_valid && byte_ready) got_q.push_back(byte_data);
            @(posedge clk); #1;
        end
        start = 1'b0; coeff_valid = 1'b0; byte_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; d = 4'd0; coeff_valid = 1'b0;
        coeff_data = 12'h000; byte_ready = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, done, err, coeff_ready, byte_valid, byte_data} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {busy, done, err, coeff_ready, byte_valid, byte_data});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_d1_alt();
        int bad;
        for (int i = 0; i < N; i++) cvals[i] = (i % 2 == 0) ? 12'd1 : 12'd0;
        run_op(4'd1, 1'b0, 0);
        tests_run++;
        if (got_q.size() !== 32 || !done_seen || err_seen || timeout || done_wide) begin
            tests_failed++;
            $display("FAIL d1_end: bytes=%0d done=%0b err=%0b to=%0b wide=%0b, want 32 1 0 0 0",
                     got_q.size(), done_seen, err_seen, timeout, done_wide);
        end
        bad = 0;
        foreach (got_q[k]) if (got_q[k] !== 8'h55) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL d1_bytes: %0d bytes differ from 0x55", bad);
        end
        tests_run++;
        if (n_coeff_hs !== N || busy_bad) begin
            tests_failed++;
            $display("FAIL d1_coeffs: coeff_hs=%0d busy_bad=%0b, want 256 0", n_coeff_hs, busy_bad);
        end
    endtask

    task automatic test_d12_ones();
        int bad;
        for (int i = 0; i < N; i++) cvals[i] = 12'hFFF;
        run_op(4'd12, 1'b0, 0);
        bad = 0;
        foreach (got_q[k]) if (got_q[k] !== 8'hFF) bad++;
        tests_run++;
        if (got_q.size() !== 384 || bad != 0 || !done_seen || err_seen) begin
            tests_failed++;
            $display("FAIL d12_ones: bytes=%0d bad=%0d done=%0b err=%0b, want 384 0 1 0",
                     got_q.size(), bad, done_seen, err_seen);
        end
    endtask

    task automatic test_d4_ramp();
        logic [7:0] exp_tab [8];
        int bad;
        exp_tab = '{8'h10, 8'h32, 8'h54, 8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE};
        for (int i = 0; i < N; i++) cvals[i] = 12'(i % 16);
        run_op(4'd4, 1'b0, 0);
        bad = 0;
        foreach (got_q[k]) if (got_q[k] !== exp_tab[k % 8]) bad++;
        tests_run++;
        if (got_q.size() !== 128 || bad != 0 || !done_seen || err_seen) begin
            tests_failed++;
            $display("FAIL d4_ramp: bytes=%0d bad=%0d done=%0b err=%0b, want 128 0 1 0",
                     got_q.size(), bad, done_seen, err_seen);
        end
    endtask

    task automatic test_d4_mask();
        int bad;
        for (int i = 0; i < N; i++) cvals[i] = 12'hFF3;
        run_op(4'd4, 1'b0, 0);
        bad = 0;
        foreach (got_q[k]) if (got_q[k] !== 8'h33) bad++;
        tests_run++;
        if (got_q.size() !== 128 || bad != 0) begin
            tests_failed++;
            $display("FAIL d4_mask: bytes=%0d bad=%0d, want 128 0", got_q.size(), bad);
        end
    endtask

    task automatic test_d10_stall();
        bit bits [$];
        logic [7:0] exp_b;
        int bad;
        for (int i = 0; i < N; i++) cvals[i] = 12'($urandom_range(0, 4095));
        for (int i = 0; i < N; i++)
            for (int b = 0; b < 10; b++) bits.push_back(cvals[i][b]);
        run_op(4'd10, 1'b1, 0);
        bad = 0;
        foreach (got_q[k]) begin
            for (int b = 0; b < 8; b++) exp_b[b] = bits[8 * k + b];
            if (got_q[k] !== exp_b) bad++;
        end
        tests_run++;
        if (got_q.size() !== 320 || bad != 0) begin
            tests_failed++;
            $display("FAIL d10_bytes: bytes=%0d bad=%0d, want 320 0", got_q.size(), bad);
        end
        tests_run++;
        if (stable_bad) begin
            tests_failed++;
            $display("FAIL d10_stall_hold: byte_data/valid changed under stall, want stable");
        end
        tests_run++;
        if (!done_seen || err_seen || timeout || done_wide || busy_bad || n_coeff_hs !== N) begin
            tests_failed++;
            $display("FAIL d10_end: done=%0b err=%0b to=%0b wide=%0b busy_bad=%0b chs=%0d, want 1 0 0 0 0 256",
                     done_seen, err_seen, timeout, done_wide, busy_bad, n_coeff_hs);
        end
    endtask

    task automatic test_illegal(input logic [3:0] dval);
        int hs;
        hs = 0;
        start = 1'b1; d = dval; coeff_valid = 1'b1; byte_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (coeff_ready || byte_valid) hs++;
        tests_run++;
        if ({busy, done, err} !== 3'b111) begin
            tests_failed++;
            $display("FAIL illegal_d%0d_fin: busy/done/err=%b, want 111", dval, {busy, done, err});
        end
        @(posedge clk); #1;
        if (coeff_ready || byte_valid) hs++;
        tests_run++;
        if ({busy, done, err} !== 3'b000 || hs != 0) begin
            tests_failed++;
            $display("FAIL illegal_d%0d_after: busy/done/err=%b hs=%0d, want 000 0",
                     dval, {busy, done, err}, hs);
        end
        coeff_valid = 1'b0; byte_ready = 1'b0;
    endtask

    task automatic test_rst_midrun();
        int bad;
        bit spurious;
        for (int i = 0; i < N; i++) cvals[i] = 12'hA00 | 12'(i);
        run_op(4'd8, 1'b0, 50);
        #3 rst = 1'b1;
        #1;
        tests_run++;
        if (got_q.size() !== 50 || {busy, done, err, coeff_ready, byte_valid, byte_data} !== 13'd0) begin
            tests_failed++;
            $display("FAIL rst_mid: bytes=%0d outs=%b, want 50 and all zero",
                     got_q.size(), {busy, done, err, coeff_ready, byte_valid, byte_data});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        spurious = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            if (done || busy) spurious = 1;
        end
        tests_run++;
        if (spurious) begin
            tests_failed++;
            $display("FAIL rst_no_done: done/busy seen after reset, want 0");
        end
        run_op(4'd8, 1'b0, 0);
        bad = 0;
        foreach (got_q[k]) if (got_q[k] !== 8'(k)) bad++;
        tests_run++;
        if (got_q.size() !== 256 || bad != 0 || !done_seen || err_seen) begin
            tests_failed++;
            $display("FAIL rst_rerun: bytes=%0d bad=%0d done=%0b err=%0b, want 256 0 1 0",
                     got_q.size(), bad, done_seen, err_seen);
        end
    endtask

    initial begin
        test_reset();
        test_d1_alt();
        test_d12_ones();
        test_d4_ramp();
        test_d4_mask();
        test_d10_stall();
        test_illegal(4'd0);
        test_illegal(4'd13);
        test_rst_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
